sram_mem_port: RTL

//  Responder side of the execute stage's data-memory request interface (mem_rd/mem_wr/mem_addr/mem_wr_data/ram_be_n).

---
 rtl/sram_mem_port_pkg.sv | 26 ++
 rtl/sram_mem_port_load_align.sv | 22 ++
 rtl/sram_mem_port.sv | 114 +++++++++++
 3 files changed

// File: rtl/sram_mem_port_pkg.sv
// Shared types and constants for the SRAM data-memory port.
// State encoding and byte-enable patterns.
package sram_mem_port_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR_SETUP,
    S_WR_PULSE,
    S_WR_HOLD,
    S_DONE
  } sram_state_t;

  localparam logic [3:0] BE_WORD   = 4'b0000;
  localparam logic [3:0] BE_BYTE_0 = 4'b1110;
  localparam logic [3:0] BE_BYTE_1 = 4'b1101;
  localparam logic [3:0] BE_BYTE_2 = 4'b1011;
  localparam logic [3:0] BE_BYTE_3 = 4'b0111;

  localparam int SRAM_AW_DEF = 20;

  function automatic logic [31:0] sext8(input logic [7:0] b);
    return {{24{b[7]}}, b};
  endfunction

endpackage

// File: rtl/sram_mem_port_load_align.sv
// Load formatter: picks the addressed byte and sign-extends it.
// Ports: be_n (latched enables), raw (SRAM word), data (aligned result).
module sram_mem_port_load_align
  import sram_mem_port_pkg::*;
(
  input  logic [3:0]  be_n,
  input  logic [31:0] raw,
  output logic [31:0] data
);

  always_comb begin
    data = raw;
    case (be_n)
      BE_BYTE_0: data = sext8(raw[7:0]);
      BE_BYTE_1: data = sext8(raw[15:8]);
      BE_BYTE_2: data = sext8(raw[23:16]);
      BE_BYTE_3: data = sext8(raw[31:24]);
      default:   data = raw;
    endcase
  end

endmodule

// File: rtl/sram_mem_port.sv
// Sequences single loads/stores from exe onto a 32-bit async SRAM.
// Ports: mem_* pipeline side, sram_* board pins, mem_stall holds exe.
module sram_mem_port
  import sram_mem_port_pkg::*;
#(
  parameter int SRAM_AW = SRAM_AW_DEF,
  parameter int RD_WAIT = 1,
  parameter int WR_WAIT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mem_rd,
  input  logic               mem_wr,
  input  logic [31:0]        mem_addr,
  input  logic [31:0]        mem_wr_data,
  input  logic [3:0]         ram_be_n,
  output logic [31:0]        mem_rd_data,
  output logic               mem_done,
  output logic               mem_stall,
  inout  wire  [31:0]        sram_data,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [3:0]         sram_be_n,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n
);

  localparam logic [2:0] RD_LAST = 3'(RD_WAIT);
  localparam logic [2:0] WR_LAST = 3'(WR_WAIT);

  sram_state_t state_q;
  sram_state_t state_d;
  logic [2:0]  cnt_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic        drive_q;
  logic [31:0] aligned;
  logic        busy_d;
  logic        accept;
  logic        unused_addr;

  assign unused_addr = ^{mem_addr[31:SRAM_AW+2], mem_addr[1:0]};

  assign mem_stall = (mem_rd | mem_wr) & (state_q != S_DONE);
  assign sram_data = drive_q ? wdata_q : 'z;

  sram_mem_port_load_align u_align (
    .be_n (be_q),
    .raw  (sram_data),
    .data (aligned)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (mem_wr) state_d = S_WR_SETUP;
        else if (mem_rd) state_d = S_RD;
      end
      S_RD:
        if (cnt_q == RD_LAST) state_d = S_DONE;
      S_WR_SETUP:
        state_d = S_WR_PULSE;
      S_WR_PULSE:
        if (cnt_q == WR_LAST) state_d = S_WR_HOLD;
      S_WR_HOLD:
        state_d = S_DONE;
      S_DONE:
        state_d = S_IDLE;
      default:
        state_d = S_IDLE;
    endcase
  end

  assign accept = (state_q == S_IDLE) && (state_d != S_IDLE);
  assign busy_d = state_d inside
    {S_RD, S_WR_SETUP, S_WR_PULSE, S_WR_HOLD};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      be_q        <= 4'b1111;
      wdata_q     <= '0;
      drive_q     <= 1'b0;
      sram_addr   <= '0;
      sram_be_n   <= 4'b1111;
      sram_ce_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
      sram_we_n   <= 1'b1;
      mem_done    <= 1'b0;
      mem_rd_data <= '0;
    end else begin
      state_q <= state_d;
      // restart the wait count on every state entry
      cnt_q   <= (state_d != state_q) ? 3'd0 : cnt_q + 3'd1;
      if (accept) begin
        be_q      <= ram_be_n;
        wdata_q   <= mem_wr_data;
        sram_addr <= mem_addr[SRAM_AW+1:2];
      end
      sram_be_n <= !busy_d ? 4'b1111 :
                   accept  ? ram_be_n : be_q;
      sram_ce_n <= !busy_d;
      sram_oe_n <= (state_d != S_RD);
      sram_we_n <= (state_d != S_WR_PULSE);
      drive_q   <= state_d inside {S_WR_SETUP, S_WR_PULSE, S_WR_HOLD};
      mem_done  <= (state_d == S_DONE);
      if (state_q == S_RD && state_d == S_DONE)
        mem_rd_data <= aligned;
    end
  end

endmodule
